// File: rtl/fpu_ss_mem_buffer.sv
// In-order memory-metadata FIFO between the FPU subsystem controller and the load/store result path.
// Optional sticky protocol-error flag is built only when FPU_SS_MEM_BUF_ERR_EN is defined.
package fpu_ss_mem_buffer_pkg;
  typedef struct packed {
    logic       we;
    logic [4:0] rd;
    logic [3:0] core_id;
  } mem_metadata_t;
endpackage

module fpu_ss_mem_buffer
  import fpu_ss_mem_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  mem_metadata_t    push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output mem_metadata_t    pop_data_o,
  output logic [CNT_W-1:0] usage_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  mem_metadata_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes use only registered occupancy, so push_ready_o never sees pop_ready_i.
  always_comb begin
    full  = (cnt == CNT_W'(DEPTH));
    empty = (cnt == '0);
    push  = push_valid_i & ~full;
    pop   = pop_ready_i & ~empty;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload is never cleared; the empty mask on pop_data_o hides stale entries.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem[wr_ptr] <= push_data_i;
  end

  always_comb begin
    push_ready_o = ~full;
    pop_valid_o  = ~empty;
    pop_data_o   = empty ? '0 : mem[rd_ptr];
    usage_o      = cnt;
    full_o       = full;
    empty_o      = empty;
  end

`ifdef FPU_SS_MEM_BUF_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (flush_i) begin
      err_q <= 1'b0;
    end else if ((pop_ready_i && empty) || (push_valid_i && full)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_ss_mem_buffer.sv
// Scoreboard bench for fpu_ss_mem_buffer: DUT 0 has DEPTH=2, DUT 1 has DEPTH=3.
module tb_fpu_ss_mem_buffer;
  import fpu_ss_mem_buffer_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush [2];
  logic          pvalid [2];
  logic          pready_o [2];
  mem_metadata_t pdata [2];
  logic          qvalid [2];
  logic          qready [2];
  mem_metadata_t qdata [2];
  logic [1:0]    usage [2];
  logic          full [2];
  logic          empty [2];
  logic          err [2];

  int npass = 0;
  int ntotal = 0;

  int            dep [2] = '{2, 3};
  mem_metadata_t m [2][16];
  int            mn [2] = '{0, 0};
  bit            merr [2] = '{1'b0, 1'b0};
  mem_metadata_t exp0 [$];
  mem_metadata_t exp1 [$];

  always #5 clk = ~clk;

  fpu_ss_mem_buffer #(.DEPTH(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[0]),
    .push_valid_i(pvalid[0]), .push_ready_o(pready_o[0]), .push_data_i(pdata[0]),
    .pop_valid_o(qvalid[0]), .pop_ready_i(qready[0]), .pop_data_o(qdata[0]),
    .usage_o(usage[0]), .full_o(full[0]), .empty_o(empty[0]), .err_o(err[0])
  );

  fpu_ss_mem_buffer #(.DEPTH(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[1]),
    .push_valid_i(pvalid[1]), .push_ready_o(pready_o[1]), .push_data_i(pdata[1]),
    .pop_valid_o(qvalid[1]), .pop_ready_i(qready[1]), .pop_data_o(qdata[1]),
    .usage_o(usage[1]), .full_o(full[1]), .empty_o(empty[1]), .err_o(err[1])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
    ntotal++;
    if (act === expv) npass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, expv, $time);
  endtask

  function automatic mem_metadata_t mk(input bit we, input int rd, input int cid);
    mem_metadata_t r;
    r.we      = we;
    r.rd      = 5'(rd);
    r.core_id = 4'(cid);
    return r;
  endfunction

  // Monitor: every accepted pop is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush[0] && qvalid[0] && qready[0]) begin
      if (exp0.size() == 0) chk("unexpected_pop", 0, 32'(qdata[0]), 32'hffff_ffff);
      else chk("pop_data", 0, 32'(qdata[0]), 32'(exp0.pop_front()));
    end
    if (!rst && !flush[1] && qvalid[1] && qready[1]) begin
      if (exp1.size() == 0) chk("unexpected_pop", 1, 32'(qdata[1]), 32'hffff_ffff);
      else chk("pop_data", 1, 32'(qdata[1]), 32'(exp1.pop_front()));
    end
  end

  // Checks status against the model, drives one cycle, then advances the model.
  task automatic step(input int k, input bit push, input mem_metadata_t d, input bit pop, input bit fl);
    int n;
    mem_metadata_t x;
    n = mn[k];
    chk("usage", k, 32'(usage[k]), 32'(n));
    chk("full", k, 32'(full[k]), 32'(n == dep[k]));
    chk("empty", k, 32'(empty[k]), 32'(n == 0));
    chk("push_ready", k, 32'(pready_o[k]), 32'(n != dep[k]));
    chk("pop_valid", k, 32'(qvalid[k]), 32'(n != 0));
    if (n == 0) chk("pop_data_masked", k, 32'(qdata[k]), 32'd0);
    chk("err", k, 32'(err[k]), 32'(merr[k]));
    pvalid[k] = push;
    pdata[k]  = d;
    qready[k] = pop;
    flush[k]  = fl;
    if (fl) begin
      mn[k]   = 0;
      merr[k] = 1'b0;
    end else begin
`ifdef FPU_SS_MEM_BUF_ERR_EN
      if ((pop && n == 0) || (push && n == dep[k])) merr[k] = 1'b1;
`endif
      if (pop && n > 0) begin
        x = m[k][0];
        for (int i = 0; i < 15; i++) m[k][i] = m[k][i + 1];
        mn[k]--;
        if (k == 0) exp0.push_back(x);
        else exp1.push_back(x);
      end
      if (push && n < dep[k]) begin
        m[k][mn[k]] = d;
        mn[k]++;
      end
    end
    @(posedge clk);
    #1;
    pvalid[k] = 1'b0;
    qready[k] = 1'b0;
    flush[k]  = 1'b0;
  endtask

  task automatic rst_chk(input int k);
    chk("rst_usage", k, 32'(usage[k]), 32'd0);
    chk("rst_full", k, 32'(full[k]), 32'd0);
    chk("rst_empty", k, 32'(empty[k]), 32'd1);
    chk("rst_push_ready", k, 32'(pready_o[k]), 32'd1);
    chk("rst_pop_valid", k, 32'(qvalid[k]), 32'd0);
    chk("rst_pop_data", k, 32'(qdata[k]), 32'd0);
    chk("rst_err", k, 32'(err[k]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_metadata_t z;
    z = '0;
    for (int k = 0; k < 2; k++) begin
      flush[k] = 1'b0; pvalid[k] = 1'b0; qready[k] = 1'b0; pdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // DUT 0 (DEPTH=2): reset state, single push latency.
    step(0, 0, z, 0, 0);
    step(0, 1, mk(1, 5, 3), 0, 0);
    step(0, 0, z, 1, 0);
    // Fill, ignored third push, drain in order.
    step(0, 1, mk(0, 1, 0), 0, 0);
    step(0, 1, mk(0, 2, 0), 0, 0);
    step(0, 1, mk(0, 3, 0), 0, 0);
    step(0, 0, z, 1, 0);
    step(0, 0, z, 1, 0);
    step(0, 0, z, 0, 0);
    // Push and pop together while full: offered entry must be dropped.
    step(0, 1, mk(1, 1, 1), 0, 0);
    step(0, 1, mk(1, 2, 2), 0, 0);
    step(0, 1, mk(1, 9, 9), 1, 0);
    step(0, 0, z, 1, 0);
    step(0, 0, z, 0, 0);
    // Flush with concurrent push while holding two entries.
    step(0, 1, mk(0, 10, 1), 0, 0);
    step(0, 1, mk(0, 11, 1), 0, 0);
    step(0, 1, mk(0, 12, 1), 0, 1);
    step(0, 0, z, 0, 0);
    // Pop while empty: sticky error only when the feature is built in.
    step(0, 0, z, 1, 0);
    step(0, 0, z, 0, 0);
    step(0, 0, z, 0, 0);
    step(0, 0, z, 0, 1);
    step(0, 0, z, 0, 0);
    // Push after flush resumes from pointer 0.
    step(0, 1, mk(1, 17, 2), 0, 0);
    step(0, 0, z, 1, 0);

    // DUT 1 (DEPTH=3): seven push/pop pairs wrap the pointers.
    step(1, 0, z, 0, 0);
    step(1, 1, mk(0, 0, 0), 0, 0);
    for (int i = 1; i < 7; i++) step(1, 1, mk(i[0], i, i), 1, 0);
    step(1, 0, z, 1, 0);
    step(1, 0, z, 0, 0);
    step(1, 1, mk(1, 20, 4), 0, 0);
    step(1, 1, mk(1, 21, 5), 0, 0);
    step(1, 1, mk(1, 22, 6), 0, 0);
    step(1, 1, mk(1, 23, 7), 1, 0);
    step(1, 0, z, 1, 0);

    // Asynchronous reset mid-burst, sampled between clock edges.
    pvalid[1] = 1'b1;
    pdata[1]  = mk(0, 30, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    rst_chk(0);
    rst_chk(1);
    mn[0] = 0; mn[1] = 0; merr[0] = 1'b0; merr[1] = 1'b0;
    pvalid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, z, 0, 0);
    step(1, 1, mk(1, 31, 1), 0, 0);
    step(1, 0, z, 1, 0);
    step(1, 0, z, 0, 0);

    chk("pending_pops", 0, 32'(exp0.size()), 32'd0);
    chk("pending_pops", 1, 32'(exp1.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/fpu_ss_mem_buffer.md
# fpu_ss_mem_buffer

Memory-metadata FIFO for the FPU subsystem's load/store path: it sits beside the subsystem controller and records one `mem_metadata_t` entry (`we`, `rd`, `core_id`) per accepted memory request, then returns the entries in order as memory results arrive. The controller pushes on every memory-request handshake and pops on every memory-result valid. It uses the head entry to write the FP register file, forward results and clear the scoreboard. The block provides in-order buffering, occupancy tracking, flush, and optional protocol-error detection.

## Interface
- `DEPTH`, default 2: number of entries; legal range 1..16; need not be a power of two.
- `CNT_W`, default `$clog2(DEPTH+1)`: occupancy counter width; derived, do not override.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous and active-high.
- `flush_i`  in  1  synchronous clear of all entries; takes priority over push and pop.
- `push_valid_i`  in  1  controller offers an entry (driven by `mem_push_valid_o`).
- `push_ready_o`  out  1  space available; equals `~full`.
- `push_data_i`  in  `mem_metadata_t`  entry to store.
- `pop_valid_o`  out  1  head entry is valid; equals `~empty`.
- `pop_ready_i`  in  1  consume the head entry (driven by `mem_pop_ready_o`).
- `pop_data_o`  out  `mem_metadata_t`  head entry; all zeros when empty.
- `usage_o`  out  `CNT_W`  current number of valid entries.
- `full_o`  out  1  `usage_o == DEPTH`.
- `empty_o`  out  1  `usage_o == 0`.
- `err_o`  out  1  sticky protocol error; present only with `FPU_SS_MEM_BUF_ERR_EN`, otherwise tied to 0.

## Operation
- Storage is a DEPTH-entry register array with write pointer `wr_ptr`, read pointer `rd_ptr` and counter `cnt`.
- Push occurs when `push_valid_i & push_ready_o`. The entry is written at `wr_ptr`, and `wr_ptr` increments and wraps from DEPTH-1 to 0.
- Pop occurs when `pop_ready_i & pop_valid_o`. `rd_ptr` increments with the same wrap rule.
- `cnt` update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
- Simultaneous push and pop while full: no push occurs because `push_ready_o` is 0. The pop proceeds and `cnt` becomes DEPTH-1.
- Simultaneous push and pop while empty: no pop occurs because `pop_valid_o` is 0. The push proceeds and `cnt` becomes 1.
- `pop_ready_i` while empty is ignored; no state changes.
- `push_valid_i` while full is ignored; no state changes.
- `flush_i` sets both pointers and `cnt` to 0 in the next cycle. Any push or pop in the same cycle is discarded.
- Stored data is not cleared by flush or reset. `pop_data_o` is masked to zero whenever empty.
- `push_ready_o` depends only on registered state. It must not depend on `pop_ready_i` combinationally, because the controller's request-valid already depends on `push_ready_o` and a dependency would create a loop.

## Timing
- Reset values: pointers = 0, `cnt` = 0, `push_ready_o` = 1, `pop_valid_o` = 0, `pop_data_o` = 0, `usage_o` = 0, `full_o` = 0, `empty_o` = 1, `err_o` = 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Latency: an entry pushed in cycle N appears on `pop_data_o` with `pop_valid_o` = 1 in cycle N+1. There is no fall-through.
- All outputs are functions of registered state only.
- Throughput is one push and one pop per cycle, sustained.
- Entries are returned in push order; there is no reordering.

## Configuration
- `FPU_SS_MEM_BUF_ERR_EN` defined: `err_o` is set on the clock after either of these events, and stays set until `rst_i` or `flush_i`:
  - `pop_ready_i` while empty (a memory result arrived with no outstanding request);
  - `push_valid_i` while full (the controller ignored `push_ready_o`).
- Macro not defined: the error logic is removed entirely, `err_o` is constant 0, and the illegal events are silently ignored as described under Operation.

## Test plan
- After reset, with DEPTH=2: push `{we=1, rd=5, core_id=3}`. Next cycle `pop_valid_o`=1, `pop_data_o.rd`=5, `usage_o`=1.
- Push `rd`=1 then `rd`=2: `full_o`=1 and `push_ready_o`=0. A third push of `rd`=3 is ignored. Two pops return 1 then 2, and `empty_o`=1.
- At full, assert push and pop together: pop returns `rd`=1, `usage_o`=1, and the offered entry is not stored.
- With DEPTH=3, run 7 push/pop pairs with `rd`=0..6: output order is 0..6, confirming pointer wrap for a non-power-of-two depth.
- Hold 2 entries and assert `flush_i` together with a push: next cycle `usage_o`=0 and `pop_valid_o`=0. Separately, assert `rst_i` mid-burst: all outputs return to reset values asynchronously.
- With `FPU_SS_MEM_BUF_ERR_EN`: pop while empty sets `err_o`=1 the next cycle, and it stays 1 until `flush_i`. Without the macro, the same stimulus leaves `err_o`=0 and `usage_o`=0.
